// File: rtl/adc_sar_ctrl.sv
// SAR ADC conversion controller: sample, binary-search the capacitive DAC against the
// comparator, optionally average 2^avg_log2 conversions, and flag comparator timeouts.
module adc_sar_ctrl #(
  parameter int unsigned N       = 12,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         start,
  input  logic [3:0]   sample_len,
  input  logic [1:0]   avg_log2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         err,
  output logic         ms_clk,
  output logic         ms_sample,
  output logic [N-1:0] ms_dac,
  input  logic         ms_rdy,
  input  logic         ms_cmp
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETTLE,
    S_COMPARE,
    S_ACCUM,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      sl_q, sl_d;
  logic [1:0]      avg_q, avg_d;
  logic [3:0]      samp_q, samp_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N-1:0]    trial_q, trial_d;
  logic [N-1:0]    dac_q, dac_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [N+2:0]    acc_q, acc_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N-1:0]    result_q, result_d;
  logic            err_q, err_d;

  logic [N-1:0]    bit_mask;
  logic [N-1:0]    trial_dec;
  logic [N+2:0]    acc_sum;
  logic [3:0]      cnt_inc;
  logic [3:0]      cnt_lim;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= S_IDLE;
      sl_q     <= '0;
      avg_q    <= '0;
      samp_q   <= '0;
      idx_q    <= '0;
      trial_q  <= '0;
      dac_q    <= '0;
      tmo_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sl_q     <= sl_d;
      avg_q    <= avg_d;
      samp_q   <= samp_d;
      idx_q    <= idx_d;
      trial_q  <= trial_d;
      dac_q    <= dac_d;
      tmo_q    <= tmo_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sl_d     = sl_q;
    avg_d    = avg_q;
    samp_d   = samp_q;
    idx_d    = idx_q;
    trial_d  = trial_q;
    dac_d    = dac_q;
    tmo_d    = tmo_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;

    bit_mask  = N'(1) << idx_q;
    trial_dec = ms_cmp ? (trial_q | bit_mask) : (trial_q & ~bit_mask);
    acc_sum   = acc_q + (N+3)'(trial_q);
    cnt_inc   = cnt_q + 4'd1;
    cnt_lim   = 4'd1 << avg_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SAMPLE;
          sl_d    = sample_len;
          avg_d   = avg_log2;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          samp_d  = '0;
          dac_d   = '0;
        end
      end
      S_SAMPLE: begin
        if (samp_q == sl_q) begin
          state_d = S_SETTLE;
          idx_d   = IW'(N - 1);
          trial_d = '0;
          dac_d   = {1'b1, {(N-1){1'b0}}};
        end else begin
          samp_d = samp_q + 4'd1;
        end
      end
      S_SETTLE: begin
        state_d = S_COMPARE;
        tmo_d   = '0;
      end
      S_COMPARE: begin
        // The strobe cycle itself is not counted as waiting, so a timeout
        // leaves COMPARE after the strobe cycle plus TIMEOUT idle cycles.
        if (ms_rdy) begin
          trial_d = trial_dec;
          if (idx_q == '0) begin
            state_d = S_ACCUM;
          end else begin
            state_d = S_SETTLE;
            idx_d   = idx_q - IW'(1);
            dac_d   = trial_dec | (bit_mask >> 1);
          end
        end else if (tmo_q == TW'(TIMEOUT)) begin
          state_d  = S_DONE;
          err_d    = 1'b1;
          result_d = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_ACCUM: begin
        acc_d = acc_sum;
        cnt_d = cnt_inc;
        if (cnt_inc < cnt_lim) begin
          state_d = S_SAMPLE;
          samp_d  = '0;
          dac_d   = '0;
        end else begin
          state_d  = S_DONE;
          result_d = N'(acc_sum >> avg_q);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q == S_SAMPLE) || (state_q == S_SETTLE) ||
                     (state_q == S_COMPARE) || (state_q == S_ACCUM);
  assign done      = (state_q == S_DONE);
  assign ms_clk    = (state_q == S_COMPARE);
  assign ms_sample = (state_q == S_SAMPLE);
  assign ms_dac    = dac_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: doc/adc_sar_ctrl.md
ADC_SAR_CTRL -- requirements
Module: adc_sar_ctrl

Interface
REQ-001 Parameter N, default 12, SAR resolution in bits (ms_dac and result width).
REQ-002 Parameter TIMEOUT, default 15, maximum cycles in COMPARE waiting for ms_rdy.
REQ-003 clk  input  1  controller clock; all state on rising edge.
REQ-004 rstb  input  1  asynchronous active-low reset.
REQ-005 start  input  1  conversion request, level-sampled in IDLE only.
REQ-006 sample_len  input  4  sample phase length minus one, in cycles.
REQ-007 avg_log2  input  2  averaging: 2^avg_log2 conversions per result.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse, result/err valid.
REQ-010 result  output  N  averaged conversion code, held until next done.
REQ-011 err  output  1  comparator timeout flag, held until next accepted start.
REQ-012 ms_clk  output  1  comparator strobe to analog SAR.
REQ-013 ms_sample  output  1  sample switch control to analog SAR.
REQ-014 ms_dac  output  N  capacitive DAC trial code.
REQ-015 ms_rdy  input  1  comparator decision valid; used without synchronizer.
REQ-016 ms_cmp  input  1  comparator decision: 1 = input above DAC level.

Function
REQ-017 FSM states SHALL be IDLE, SAMPLE, SETTLE, COMPARE, ACCUM, DONE.
REQ-018 IDLE: start=1 -> SAMPLE next cycle; sample_len and avg_log2 latched, accumulator, conversion counter and err cleared.
REQ-019 SAMPLE: ms_sample=1 for exactly sample_len+1 cycles, ms_dac=0, then SETTLE with bit index N-1 and trial register 0.
REQ-020 SETTLE (1 cycle): ms_dac = trial | (1<<idx), ms_clk=0; then COMPARE.
REQ-021 COMPARE: ms_clk=1, ms_dac held; each cycle ms_rdy=1 -> bit idx of trial set to ms_cmp, ms_clk drops next cycle.
REQ-022 After decision: idx>0 -> SETTLE with idx-1; idx=0 -> ACCUM.
REQ-023 COMPARE timeout: TIMEOUT consecutive cycles with ms_rdy=0 -> err=1, result=0, go DONE (remaining averaging aborted).
REQ-024 ACCUM (1 cycle): accumulator (N+3 bits) += trial; conversion counter+1; counter < 2^avg_log2 -> SAMPLE, else DONE.
REQ-025 DONE (1 cycle): done=1, result = accumulator >> avg_log2 (truncating), busy=0 in the same cycle; then IDLE.
REQ-026 start asserted while busy SHALL be ignored, not queued.
REQ-027 ms_sample and ms_clk SHALL never be high in the same cycle.
REQ-028 ms_dac SHALL change only in SETTLE or when entering SAMPLE; stable throughout COMPARE.
REQ-029 Latency, start cycle = 0, ms_rdy returned k cycles after ms_clk rises: done at cycle 2^avg_log2 * (sample_len+1 + N*(2+k) + 1) + 1.
REQ-030 start held high continuously SHALL start a new conversion on the cycle after DONE (IDLE 1 cycle).

Reset
REQ-031 rstb=0 SHALL asynchronously force IDLE; busy, done, err, ms_clk, ms_sample = 0; ms_dac, result, accumulator, counters = 0.
REQ-032 Reset mid-conversion SHALL abort without a done pulse; first start after rstb rises behaves as REQ-018.

Verification
REQ-033 Bench comparator ms_cmp=(ms_dac<=0xA5C), ms_rdy 1 cycle after ms_clk; sample_len=3, avg_log2=0, start pulse -> done at cycle 42, result=0xA5C, err=0.
REQ-034 Same comparator, avg_log2=2, target alternating 0x400/0x403 per conversion -> one done only, result=0x401.
REQ-035 ms_rdy never asserted -> err=1, result=0, done at cycle 1+4+1+15+1 with sample_len=3; next start clears err.
REQ-036 Target 0xFFF and 0x000 -> results 0xFFF and 0x000; ms_dac trial sequence for 0x000: 0x800,0x400,...,0x001.
REQ-037 rstb pulsed low during COMPARE of bit 5 -> all outputs 0 immediately, no done; fresh conversion then correct.
REQ-038 Assertions every cycle: REQ-027, REQ-028, done one cycle wide, start during busy ignored.
